// File: rtl/address_unit_pkg.sv
// rtl/address_unit_pkg.sv - shared control-bit indices, latch states and addressing-mode codes
package addr_pkg;

    localparam int CTRL_PC_OUT = 3;
    localparam int CTRL_PC_INC = 2;
    localparam int CTRL_LDLO   = 1;
    localparam int CTRL_LDHI   = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LO_HELD = 2'd1,
        FIXUP   = 2'd2,
        VALID   = 2'd3
    } addr_state_t;

    localparam logic [2:0] ADDR_MODE_IMP  = 3'd0;
    localparam logic [2:0] ADDR_MODE_ZP   = 3'd1;
    localparam logic [2:0] ADDR_MODE_ZPX  = 3'd2;
    localparam logic [2:0] ADDR_MODE_ABS  = 3'd3;
    localparam logic [2:0] ADDR_MODE_ABSX = 3'd4;
    localparam logic [2:0] ADDR_MODE_ABSY = 3'd5;
    localparam logic [2:0] ADDR_MODE_IND  = 3'd6;

endpackage

// File: rtl/address_unit_pc_reg.sv
// rtl/address_unit_pc_reg.sv - 16-bit program counter with load, increment and reset vector
module pc_reg #(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inc,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic [15:0] o_pc
);

    logic [15:0] r_pc;

    // A load (jump) takes precedence over a same-edge increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + 16'd1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/address_unit.sv
// rtl/address_unit.sv - PC, operand address latch with indexed page-cross fixup, address bus mux
module address_unit
    import addr_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_ctrl,
    input  logic [7:0]  i_data,
    input  logic        i_index_en,
    input  logic [7:0]  i_index,
    input  logic        i_jmp,
    output logic [15:0] o_addr,
    output logic [15:0] o_pc,
    output logic [15:0] o_ea,
    output logic        o_ea_valid,
    output logic        o_page_cross,
    output logic        o_busy
);

    addr_state_t r_state;
    logic [7:0]  r_adl;
    logic [7:0]  r_adh;
    logic        r_carry;
    logic        r_page_cross;

    logic        w_pc_out;
    logic        w_pc_inc;
    logic        w_ldlo;
    logic        w_ldhi;
    logic [7:0]  w_index_add;
    logic [8:0]  w_sum;
    logic        w_jmp_ok;
    logic [15:0] w_ea;

    assign w_pc_out    = i_ctrl[CTRL_PC_OUT];
    assign w_pc_inc    = i_ctrl[CTRL_PC_INC];
    assign w_ldlo      = i_ctrl[CTRL_LDLO];
    assign w_ldhi      = i_ctrl[CTRL_LDHI] & ~w_ldlo;
    assign w_index_add = i_index_en ? i_index : 8'h00;
    assign w_sum       = {1'b0, i_data} + {1'b0, w_index_add};
    assign w_ea        = {r_adh, r_adl};
    assign w_jmp_ok    = i_jmp & (r_state == VALID);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (w_pc_inc),
        .i_load     (w_jmp_ok),
        .i_load_val (w_ea),
        .o_pc       (o_pc)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_adl        <= 8'h00;
            r_adh        <= 8'h00;
            r_carry      <= 1'b0;
            r_page_cross <= 1'b0;
        end else begin
            case (r_state)
                // The fixup cycle owns the latch: load strobes are dropped here.
                FIXUP: begin
                    r_adh   <= r_adh + 8'd1;
                    r_carry <= 1'b0;
                    r_state <= VALID;
                end
                default: begin
                    if (w_ldlo) begin
                        r_adl        <= w_sum[7:0];
                        r_carry      <= w_sum[8];
                        r_page_cross <= 1'b0;
                        r_state      <= LO_HELD;
                    end else if (w_ldhi) begin
                        r_adh <= i_data;
                        if (r_state == LO_HELD && r_carry) begin
                            r_page_cross <= 1'b1;
                            r_state      <= FIXUP;
                        end else begin
                            r_carry <= 1'b0;
                            r_state <= VALID;
                        end
                    end
                end
            endcase
        end
    end

    assign o_addr       = w_pc_out ? o_pc : w_ea;
    assign o_ea         = w_ea;
    assign o_ea_valid   = (r_state == VALID);
    assign o_page_cross = r_page_cross;
    assign o_busy       = (r_state == FIXUP);

endmodule

// File: tb/tb_address_unit.sv
// tb/tb_address_unit.sv - directed vector bench for address_unit
module tb_address_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  ctrl;
    logic [7:0]  data;
    logic        index_en;
    logic [7:0]  index_v;
    logic        jmp;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [15:0] ea;
    logic        ea_valid;
    logic        page_cross;
    logic        busy;

    int errors = 0;
    int checks = 0;

    address_unit dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ctrl       (ctrl),
        .i_data       (data),
        .i_index_en   (index_en),
        .i_index      (index_v),
        .i_jmp        (jmp),
        .o_addr       (addr),
        .o_pc         (pc),
        .o_ea         (ea),
        .o_ea_valid   (ea_valid),
        .o_page_cross (page_cross),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  ctrl;
        logic [7:0]  data;
        logic        ien;
        logic [7:0]  idx;
        logic        jmp;
        logic [15:0] e_pc;
        logic [15:0] e_addr;
        logic [15:0] e_ea;
        logic        e_valid;
        logic        e_pcx;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " pc"},    pc,                  v.e_pc);
        check({tag, " addr"},  addr,                v.e_addr);
        check({tag, " ea"},    ea,                  v.e_ea);
        check({tag, " valid"}, {15'd0, ea_valid},   {15'd0, v.e_valid});
        check({tag, " pcx"},   {15'd0, page_cross}, {15'd0, v.e_pcx});
        check({tag, " busy"},  {15'd0, busy},       {15'd0, v.e_busy});
    endtask

    task automatic add(input logic r, input logic [3:0] c, input logic [7:0] d, input logic ie,
                       input logic [7:0] ix, input logic j, input logic [15:0] epc,
                       input logic [15:0] eaddr, input logic [15:0] eea, input logic ev,
                       input logic ep, input logic eb);
        vec_t v;
        v = '{r, c, d, ie, ix, j, epc, eaddr, eea, ev, ep, eb};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst      = v.rst;
        ctrl     = v.ctrl;
        data     = v.data;
        index_en = v.ien;
        index_v  = v.idx;
        jmp      = v.jmp;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; ctrl = 4'b0000; data = 8'h00; index_en = 1'b0; index_v = 8'h00; jmp = 1'b0;

        //   rst ctrl     data  ien idx   jmp pc       addr     ea       v  pcx busy
        add(1, 4'b1000, 8'h00, 0, 8'h00, 0, 16'hFFFC, 16'hFFFC, 16'h0000, 0, 0, 0);
        add(0, 4'b0100, 8'h00, 0, 8'h00, 0, 16'hFFFD, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 4'b0100, 8'h00, 0, 8'h00, 0, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 4'b0100, 8'h00, 0, 8'h00, 0, 16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 4'b1100, 8'h00, 0, 8'h00, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 4'b1110, 8'h34, 0, 8'h00, 0, 16'h0001, 16'h0001, 16'h0034, 0, 0, 0);
        add(0, 4'b1101, 8'h12, 0, 8'h00, 0, 16'h0002, 16'h0002, 16'h1234, 1, 0, 0);
        add(0, 4'b0000, 8'h00, 0, 8'h00, 0, 16'h0002, 16'h1234, 16'h1234, 1, 0, 0);
        add(0, 4'b0100, 8'h00, 0, 8'h00, 1, 16'h1234, 16'h1234, 16'h1234, 1, 0, 0);
        add(0, 4'b0010, 8'h10, 1, 8'h05, 0, 16'h1234, 16'h1215, 16'h1215, 0, 0, 0);
        add(0, 4'b0000, 8'h00, 1, 8'h05, 1, 16'h1234, 16'h1215, 16'h1215, 0, 0, 0);
        add(0, 4'b0001, 8'h20, 1, 8'h05, 0, 16'h1234, 16'h2015, 16'h2015, 1, 0, 0);
        add(0, 4'b0010, 8'h80, 1, 8'hFF, 0, 16'h1234, 16'h207F, 16'h207F, 0, 0, 0);
        add(0, 4'b0001, 8'h20, 1, 8'hFF, 0, 16'h1234, 16'h207F, 16'h207F, 0, 1, 1);
        add(0, 4'b0000, 8'h00, 1, 8'hFF, 0, 16'h1234, 16'h217F, 16'h217F, 1, 1, 0);
        add(0, 4'b0010, 8'h80, 1, 8'hFF, 0, 16'h1234, 16'h217F, 16'h217F, 0, 0, 0);
        add(0, 4'b0001, 8'hFF, 1, 8'hFF, 0, 16'h1234, 16'hFF7F, 16'hFF7F, 0, 1, 1);
        add(0, 4'b0110, 8'h55, 0, 8'h00, 0, 16'h1235, 16'h007F, 16'h007F, 1, 1, 0);
        add(0, 4'b0001, 8'h44, 0, 8'h00, 0, 16'h1235, 16'h447F, 16'h447F, 1, 1, 0);
        add(0, 4'b0011, 8'h66, 0, 8'h00, 0, 16'h1235, 16'h4466, 16'h4466, 0, 0, 0);
        add(0, 4'b0010, 8'h80, 1, 8'hFF, 0, 16'h1235, 16'h447F, 16'h447F, 0, 0, 0);
        add(0, 4'b0001, 8'h10, 1, 8'hFF, 0, 16'h1235, 16'h107F, 16'h107F, 0, 1, 1);
        add(1, 4'b0000, 8'h00, 0, 8'h00, 0, 16'hFFFC, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 4'b0001, 8'hAB, 0, 8'h00, 0, 16'hFFFC, 16'hAB00, 16'hAB00, 1, 0, 0);
        add(0, 4'b1000, 8'h00, 0, 8'h00, 0, 16'hFFFC, 16'hFFFC, 16'hAB00, 1, 0, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset pc", pc, 16'hFFFC);
        check("reset valid", {15'd0, ea_valid}, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset landing mid-FIXUP, checked before any further edge.
        @(negedge clk);
        rst = 1'b0; jmp = 1'b0; ctrl = 4'b0110; data = 8'h80; index_en = 1'b1; index_v = 8'hFF;
        @(negedge clk);
        ctrl = 4'b0001; data = 8'h20;
        @(posedge clk);
        #1;
        check("pre-async busy", {15'd0, busy}, 16'd1);
        check("pre-async pc", pc, 16'hFFFD);
        ctrl = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        v = '{1'b1, 4'b0000, 8'h00, 1'b0, 8'h00, 1'b0,
              16'hFFFC, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        check_all("async rst", v);
        @(posedge clk);
        #1;
        check("async rst hold ea", ea, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/address_unit.md
Name: address_unit

Overview:
- Address datapath directly downstream of address_fsm.
- Consumes address_fsm's 4-bit control word {pc_out, pc_inc, ldlo, ldhi}.
- Owns the program counter (PC) and the operand address latch (ADH:ADL), applies optional X/Y indexing with 6502-style page-cross fixup, and drives the 16-bit memory address bus.
- Reports when the effective address (EA) is ready for the execute stage.

Parameters:
- RESET_PC, 16'hFFFC, PC value loaded on reset (reset vector fetch address).

Ports:
- i_clk  in  1  system clock, all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_ctrl  in  4  {pc_out, pc_inc, ldlo, ldhi}, bit 3 = pc_out
- i_data  in  8  read data bus
- i_index_en  in  1  add i_index to the low byte on ldlo
- i_index  in  8  selected index register value (X or Y)
- i_jmp  in  1  load PC from ADH:ADL on this edge
- o_addr  out  16  memory address bus
- o_pc  out  16  current PC
- o_ea  out  16  latched effective address {ADH, ADL}
- o_ea_valid  out  1  EA complete and stable
- o_page_cross  out  1  indexed low-byte add carried out
- o_busy  out  1  fixup cycle in progress

Behaviour:
- Reset (async, i_rst=1):
  - PC = RESET_PC, ADL = ADH = 0, carry = 0, state = IDLE.
  - o_ea_valid = 0, o_page_cross = 0, o_busy = 0.
- o_addr is combinational: pc_out ? PC : {ADH, ADL}. Same-cycle, zero latency.
- pc_inc:
  - PC <= PC + 1 mod 2^16 (16'hFFFF wraps to 16'h0000).
- i_jmp:
  - PC <= {ADH, ADL}, honoured only when o_ea_valid = 1; ignored otherwise.
  - When i_jmp and pc_inc are asserted together and i_jmp is honoured, i_jmp wins.
- ldlo:
  - sum[8:0] = i_data + (i_index_en ? i_index : 0).
  - ADL <= sum[7:0], carry <= sum[8].
  - Always restarts the sequence: clears o_ea_valid, o_page_cross and any pending fixup.
- ldhi:
  - ADH <= i_data.
  - If carry = 1: o_page_cross <= 1 and go to FIXUP.
  - If carry = 0: go to VALID.
- ldlo and ldhi asserted together: ldlo wins, ldhi is ignored for that edge.
- ldhi with no prior ldlo (state IDLE): ADH is loaded, ADL is kept, carry = 0, go to VALID.
- States:
  - IDLE: ldlo -> LO_HELD; ldhi -> VALID.
  - LO_HELD: ldhi -> FIXUP if carry, else VALID; ldlo -> LO_HELD (reload).
  - FIXUP: exactly one cycle; ADH <= ADH + 1 mod 256, carry <= 0, o_busy = 1. Go to VALID unconditionally. Any ldlo/ldhi during FIXUP is ignored.
  - VALID: o_ea_valid = 1; ldlo -> LO_HELD; ldhi -> ADH reload, stays VALID.
- Latency: o_ea_valid rises the cycle after the ldhi edge with no carry, or one cycle later with carry.
- o_page_cross:
  - Set together with entry to FIXUP.
  - Held while VALID, cleared by ldlo or reset.
- o_busy = (state == FIXUP).
- Reset asserted mid-FIXUP: returns to IDLE immediately, no ADH increment.
- PC updates are independent of the latch state machine; pc_inc is honoured in every state, including FIXUP.

Decomposition:
- Shared package (addr_pkg) holds:
  - control-bit index constants CTRL_PC_OUT=3, CTRL_PC_INC=2, CTRL_LDLO=1, CTRL_LDHI=0;
  - the addr_state_t enum {IDLE, LO_HELD, FIXUP, VALID};
  - the existing ADDR_MODE_* constants, migrated from macros.
- One natural sub-module: pc_reg (16-bit PC with increment, load and reset value).
- The latch, index adder and state machine stay in address_unit.

Test Plan:
- Reset: after i_rst pulse with no ctrl -> o_pc=16'hFFFC, o_addr=16'hFFFC, o_ea_valid=0; pc_inc x4 -> o_pc=16'h0000 (wrap).
- Absolute, no index:
  - cycle 1: i_ctrl=1110, i_data=8'h34; cycle 2: i_ctrl=1101, i_data=8'h12.
  - Next cycle: o_ea=16'h1234, o_ea_valid=1, o_page_cross=0; PC advanced by 2.
- Indexed, no cross: i_index_en=1, i_index=8'h05, lo=8'h10, hi=8'h20 -> o_ea=16'h2015 valid one cycle after ldhi, o_busy never 1.
- Indexed, page cross: i_index=8'hFF, lo=8'h80, hi=8'h20.
  - Cycle after ldhi: o_busy=1, o_ea_valid=0, o_page_cross=1.
  - Following cycle: o_ea=16'h217F, o_ea_valid=1.
  - Repeat with hi=8'hFF -> o_ea=16'h007F.
- Jump: after EA 16'h1234 valid, assert i_jmp with pc_inc -> o_pc=16'h1234. i_jmp while o_ea_valid=0 -> PC unchanged.
- Reset mid-operation: assert i_rst during FIXUP -> next sample: o_busy=0, o_ea_valid=0, o_pc=16'hFFFC, o_ea=16'h0000.
